simd_vector_engine: RTL and testbench

Parametrised successor to the fixed four-lane SIMD unit. It accepts vector instructions (opcode, lane mask, operand A, operand B) over a valid/ready handshake and buffers them in an internal instruction FIFO. Each instruction executes across LANES parallel WIDTH-bit lanes with per-lane accumulators, and results are returned over a back-pressured valid/ready output port. The block sits between the memory controller / core control and the result consumer, and replaces the separate clk/clk_2 scheme with one clock.

---
 rtl/simd_vector_engine.sv | 190 +++++++++++++++++++
 tb/tb_simd_vector_engine.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_vector_engine.sv
// LANES-wide SIMD execute unit: instruction FIFO -> issue register (p1) -> compute/output register (p2).
// Per-lane accumulators commit only when a result loads into the output register.
module simd_vector_engine #(
   parameter int LANES = 4,
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2:0]                   in_opcode,
   input  logic [LANES-1:0]             in_mask,
   input  logic [LANES*WIDTH-1:0]       in_opa,
   input  logic [LANES*WIDTH-1:0]       in_opb,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*WIDTH-1:0]       out_result,
   output logic [LANES*WIDTH-1:0]       out_extra,
   output logic [LANES-1:0]             out_zero,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
   output logic                         busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = 3 + LANES + 2*LANES*WIDTH;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_MAC = 3'd6;
   localparam logic [2:0] OP_CLR = 3'd7;

   // Returns {extra, result} for one enabled lane.
   function automatic logic [2*WIDTH-1:0] lane_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [WIDTH-1:0] acc
   );
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH:0]     sum;
      logic [WIDTH-1:0]   res;
      logic [WIDTH-1:0]   ext;
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      sum  = '0;
      res  = '0;
      ext  = '0;
      case (op)
         OP_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            res = sum[WIDTH-1:0];
            ext = WIDTH'(sum[WIDTH]);
         end
         OP_SUB: begin
            sum = {1'b0, a} - {1'b0, b};
            res = sum[WIDTH-1:0];
            ext = WIDTH'(sum[WIDTH]);
         end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_MUL: begin
            res = prod[WIDTH-1:0];
            ext = prod[2*WIDTH-1:WIDTH];
         end
         OP_MAC: begin
            res = acc + prod[WIDTH-1:0];
            ext = prod[2*WIDTH-1:WIDTH];
         end
         default: begin
         end
      endcase
      return {ext, res};
   endfunction

   logic [IW-1:0]          r_fifo_mem [DEPTH];
   logic [AW-1:0]          r_wptr;
   logic [AW-1:0]          r_rptr;
   logic [CW-1:0]          r_count;
   logic                   r_init;
   logic                   r_vld_p1;
   logic [IW-1:0]          r_instr_p1;
   logic                   r_vld_p2;
   logic [LANES*WIDTH-1:0] r_res_p2;
   logic [LANES*WIDTH-1:0] r_ext_p2;
   logic [LANES-1:0]       r_zero_p2;
   logic [WIDTH-1:0]       r_acc [LANES];

   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_adv;
   logic [2:0]             w_op_p1;
   logic [LANES-1:0]       w_mask_p1;
   logic [LANES*WIDTH-1:0] w_opa_p1;
   logic [LANES*WIDTH-1:0] w_opb_p1;
   logic [2*WIDTH-1:0]     w_lane;
   logic [LANES*WIDTH-1:0] w_res;
   logic [LANES*WIDTH-1:0] w_ext;
   logic [LANES-1:0]       w_zero;
   logic [WIDTH-1:0]       w_acc_nxt [LANES];

   // in_ready looks only at the full flag, so a pop never frees a slot for a same-cycle push.
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign in_ready = r_init & ~w_full;
   assign w_push   = in_valid & in_ready;
   assign w_adv    = ~r_vld_p2 | out_ready;
   assign w_pop    = w_adv & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_fifo_mem[r_wptr] <= {in_opcode, in_mask, in_opa, in_opb};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_init   <= 1'b0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_vld_p1 <= 1'b0;
      end else begin
         r_init <= 1'b1;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_adv) r_vld_p1 <= ~w_empty;
      end
   end

   // ---- stage p1: issue register ----
   always_ff @(posedge clk) begin
      if (w_pop) r_instr_p1 <= r_fifo_mem[r_rptr];
   end

   assign {w_op_p1, w_mask_p1, w_opa_p1, w_opb_p1} = r_instr_p1;

   always_comb begin
      w_lane    = '0;
      w_res     = '0;
      w_ext     = '0;
      w_zero    = '0;
      w_acc_nxt = r_acc;
      for (int i = 0; i < LANES; i++) begin
         w_lane = lane_op(w_op_p1, w_opa_p1[i*WIDTH +: WIDTH], w_opb_p1[i*WIDTH +: WIDTH], r_acc[i]);
         if (w_mask_p1[i]) begin
            w_res[i*WIDTH +: WIDTH] = w_lane[WIDTH-1:0];
            w_ext[i*WIDTH +: WIDTH] = w_lane[2*WIDTH-1:WIDTH];
            if ((w_op_p1 == OP_MAC) || (w_op_p1 == OP_CLR)) w_acc_nxt[i] = w_lane[WIDTH-1:0];
         end
         w_zero[i] = (w_res[i*WIDTH +: WIDTH] == '0);
      end
   end

   // ---- stage p2: output register and accumulator commit ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld_p2  <= 1'b0;
         r_res_p2  <= '0;
         r_ext_p2  <= '0;
         r_zero_p2 <= '1;
         for (int i = 0; i < LANES; i++) r_acc[i] <= '0;
      end else if (w_adv) begin
         r_vld_p2 <= r_vld_p1;
         if (r_vld_p1) begin
            r_res_p2  <= w_res;
            r_ext_p2  <= w_ext;
            r_zero_p2 <= w_zero;
            r_acc     <= w_acc_nxt;
         end
      end
   end

   assign out_valid  = r_vld_p2;
   assign out_result = r_res_p2;
   assign out_extra  = r_ext_p2;
   assign out_zero   = r_zero_p2;
   assign fifo_count = r_count;
   assign busy       = (r_count != '0) | r_vld_p1 | r_vld_p2;

endmodule

// File: tb/tb_simd_vector_engine.sv
// Bench for simd_vector_engine: queue-based result model checked every output cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_simd_vector_engine;
   localparam int LANES = 4;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd5;
   localparam logic [2:0] OP_MAC = 3'd6;
   localparam logic [2:0] OP_CLR = 3'd7;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   in_opcode;
   logic [3:0]   in_mask;
   logic [127:0] in_opa;
   logic [127:0] in_opb;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_result;
   logic [127:0] out_extra;
   logic [3:0]   out_zero;
   logic [2:0]   fifo_count;
   logic         busy;

   simd_vector_engine #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_mask(in_mask),
      .in_opa(in_opa), .in_opb(in_opb),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_extra(out_extra), .out_zero(out_zero), .fifo_count(fifo_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] res;
      logic [127:0] ext;
      logic [3:0]   z;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_acc [4];
   int          out_cyc[$];
   int          checks = 0;
   int          failures = 0;
   int          n_out = 0;
   int          cyc = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Expected per-lane results, in program order, from plain arithmetic.
   function automatic void model_push(input logic [2:0] op, input logic [3:0] m,
                                      input logic [127:0] a, input logic [127:0] b);
      exp_t        e;
      logic [31:0] x, y, r, ex;
      logic [63:0] prod, sum;
      e.res = '0;
      e.ext = '0;
      e.z   = '0;
      for (int i = 0; i < 4; i++) begin
         x    = a[i*32 +: 32];
         y    = b[i*32 +: 32];
         r    = 32'd0;
         ex   = 32'd0;
         prod = 64'(x) * 64'(y);
         sum  = 64'(x) + 64'(y);
         if (m[i]) begin
            case (op)
               3'd0: begin r = sum[31:0]; ex = 32'(sum[32]); end
               3'd1: begin r = x - y; ex = (x < y) ? 32'd1 : 32'd0; end
               3'd2: r = x & y;
               3'd3: r = x | y;
               3'd4: r = x ^ y;
               3'd5: begin r = prod[31:0]; ex = prod[63:32]; end
               3'd6: begin m_acc[i] = m_acc[i] + prod[31:0]; r = m_acc[i]; ex = prod[63:32]; end
               default: m_acc[i] = 32'd0;
            endcase
         end
         e.res[i*32 +: 32] = r;
         e.ext[i*32 +: 32] = ex;
         e.z[i] = (r == 32'd0);
      end
      q.push_back(e);
   endfunction

   // Compare process: every cycle with out_valid high must match the oldest expected result.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (reset !== 1'b1) begin
            q.delete();
            for (int i = 0; i < 4; i++) m_acc[i] = 32'd0;
         end else begin
            if (out_valid) begin
               if (q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output actual=%h required=no_result", out_result);
               end else begin
                  chk("out_result", out_result, q[0].res);
                  chk("out_extra", out_extra, q[0].ext);
                  chk("out_zero", 128'(out_zero), 128'(q[0].z));
                  if (out_ready) begin
                     void'(q.pop_front());
                     n_out++;
                     out_cyc.push_back(cyc);
                  end
               end
            end
            if (in_valid && in_ready) model_push(in_opcode, in_mask, in_opa, in_opb);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] m, input logic [127:0] a, input logic [127:0] b);
      bit ok;
      ok        = 1'b0;
      in_opcode = op;
      in_mask   = m;
      in_opa    = a;
      in_opb    = b;
      in_valid  = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         step();
      end
      in_valid = 1'b0;
      chk("send_accepted", 128'(ok), 128'(1));
   endtask

   task automatic wait_outs(input int target, input int budget);
      int t;
      t = 0;
      while (n_out < target && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("outputs_arrived", 128'(n_out >= target), 128'(1));
   endtask

   task automatic check_consec(input string name, input int n);
      int span;
      span = -1;
      if (out_cyc.size() >= n) span = out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-n];
      chk(name, 128'(span), 128'(n-1));
   endtask

   task automatic expect_next(input string name, input logic [127:0] res, input logic [127:0] ext, input logic [3:0] z);
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_valid"}, 128'(out_valid), 128'(1));
      chk({name, "_res"}, out_result, res);
      chk({name, "_ext"}, out_extra, ext);
      chk({name, "_zero"}, 128'(out_zero), 128'(z));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_opcode = 3'd0;
      in_mask   = 4'd0;
      in_opa    = '0;
      in_opb    = '0;
      out_ready = 1'b1;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_fifo_count", 128'(fifo_count), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_out_zero", 128'(out_zero), 128'(4'hF));
      chk("rst_out_result", out_result, 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("rdy_after_reset", 128'(in_ready), 128'(1));

      // ADD with carry and mask, latency of two edges
      step();
      send(OP_ADD, 4'b0111, {32'h3, 32'h2, 32'h1, 32'hFFFF_FFFF}, {4{32'h1}});
      @(negedge clk);
      chk("add_lat_k", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("add_lat_k1", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("add_lat_k2", 128'(out_valid), 128'(1));
      chk("add_res", out_result, {32'h0, 32'h3, 32'h2, 32'h0});
      chk("add_ext", out_extra, {32'h0, 32'h0, 32'h0, 32'h1});
      chk("add_zero", 128'(out_zero), 128'(4'b1001));

      // MUL and SUB on lane 0
      step();
      send(OP_MUL, 4'b0001, {96'h0, 32'hFFFF_FFFF}, {96'h0, 32'h2});
      send(OP_SUB, 4'b0001, {96'h0, 32'h3}, {96'h0, 32'h5});
      expect_next("mul", {96'h0, 32'hFFFF_FFFE}, {96'h0, 32'h1}, 4'b1110);
      expect_next("sub", {96'h0, 32'hFFFF_FFFE}, {96'h0, 32'h1}, 4'b1110);

      // CLRACC, MAC, MAC with a 5-cycle stall between the MAC results
      step();
      out_ready = 1'b0;
      send(OP_CLR, 4'hF, '0, '0);
      send(OP_MAC, 4'b0001, {96'h0, 32'd3}, {96'h0, 32'd4});
      send(OP_MAC, 4'b0001, {96'h0, 32'd3}, {96'h0, 32'd4});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mac_stall_res", out_result, {96'h0, 32'd12});
      end
      step();
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("mac2_valid", 128'(out_valid), 128'(1));
      chk("mac2_res", out_result, {96'h0, 32'd24});

      // Full FIFO under back-pressure, refused push during a pop
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         send(OP_ADD, 4'hF, {32'hFFFF_FFFF, 32'(i), 32'(i*3), 32'h1234},
                            {32'(i), 32'h10, 32'(i*5), 32'(i)});
      n0 = n_out;
      @(negedge clk);
      chk("full_count", 128'(fifo_count), 128'(4));
      chk("full_in_ready", 128'(in_ready), 128'(0));
      chk("full_busy", 128'(busy), 128'(1));
      chk("full_out_valid", 128'(out_valid), 128'(1));
      step();
      in_opcode = OP_ADD;
      in_mask   = 4'hF;
      in_opa    = {4{32'h7777_7777}};
      in_opb    = {4{32'h1}};
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("push_refused", 128'(in_ready), 128'(0));
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("count_after_pop", 128'(fifo_count), 128'(3));
      wait_outs(n0 + 6, 30);
      check_consec("drain_consecutive", 6);

      // Streaming: 20 back-to-back ADDs
      step();
      n0 = n_out;
      for (int i = 0; i < 20; i++)
         send(OP_ADD, 4'hF, {32'(i*32'h1111_1111), 32'hFFFF_FFF0 + 32'(i), 32'(i), 32'h8000_0000},
                            {32'(i), 32'h10, 32'(i*7), 32'h8000_0000});
      wait_outs(n0 + 20, 60);
      check_consec("stream_consecutive", 20);

      // Reset mid-operation discards everything
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(OP_ADD, 4'hF, {4{32'(i + 1)}}, {4{32'h5}});
      n0 = n_out;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_fifo_count", 128'(fifo_count), 128'(0));
      chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
      chk("mid_rst_out_zero", 128'(out_zero), 128'(4'hF));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("rdy_after_mid_reset", 128'(in_ready), 128'(1));
      step();
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("nothing_after_reset", 128'(n_out), 128'(n0));

      // Accumulators restart from zero after reset
      step();
      send(OP_MAC, 4'b0011, {64'h0, 32'd2, 32'd7}, {64'h0, 32'd9, 32'd5});
      expect_next("mac_after_reset", {64'h0, 32'd18, 32'd35}, '0, 4'b1100);

      repeat (5) @(negedge clk);
      chk("queue_drained", 128'(q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
